// File: rtl/maple_tx.sv
// Maple bus frame transmitter: serialises a byte stream onto SDCKA/SDCKB with
// start pattern, alternating-phase data bits, optional XOR CRC and end pattern.
module maple_tx #(
    parameter int STEP_CYCLES = 18,
    parameter bit APPEND_CRC  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       pin1_out,
    output logic       pin5_out,
    output logic       pin_oe
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BITS  = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [3:0]      r_step, w_step;
    logic [2:0]      r_bit, w_bit;
    logic            r_phase, w_phase;
    logic [7:0]      r_shift, w_shift;
    logic [7:0]      r_hold, w_hold;
    logic            r_hold_full, w_hold_full;
    logic            r_last_seen, w_last_seen;
    logic [7:0]      r_crc, w_crc;
    logic            r_crc_sent, w_crc_sent;
    logic            r_tx_ready, r_busy, r_done, r_error, r_pin1, r_pin5, r_oe;
    logic            w_tx_ready, w_done, w_error, w_pin1, w_pin5, w_oe;
    logic            w_accept, w_step_end, w_boundary, w_clk_line;

    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign pin1_out = r_pin1;
    assign pin5_out = r_pin5;
    assign pin_oe   = r_oe;

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_step      <= 4'd0;
            r_bit       <= 3'd0;
            r_phase     <= 1'b0;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_last_seen <= 1'b0;
            r_crc       <= 8'h00;
            r_crc_sent  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pin1      <= 1'b1;
            r_pin5      <= 1'b1;
            r_oe        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_step      <= w_step;
            r_bit       <= w_bit;
            r_phase     <= w_phase;
            r_shift     <= w_shift;
            r_hold      <= w_hold;
            r_hold_full <= w_hold_full;
            r_last_seen <= w_last_seen;
            r_crc       <= w_crc;
            r_crc_sent  <= w_crc_sent;
            r_tx_ready  <= w_tx_ready;
            r_busy      <= w_oe;
            r_done      <= w_done;
            r_error     <= w_error;
            r_pin1      <= w_pin1;
            r_pin5      <= w_pin5;
            r_oe        <= w_oe;
        end
    end

    // Next-state logic: step sequencing, holding register and byte-boundary priority.
    always_comb begin
        w_state     = r_state;
        w_cnt       = (r_cnt == STEP_LAST) ? '0 : r_cnt + {{(CW-1){1'b0}}, 1'b1};
        w_step      = r_step;
        w_bit       = r_bit;
        w_phase     = r_phase;
        w_shift     = r_shift;
        w_hold      = r_hold;
        w_hold_full = r_hold_full;
        w_last_seen = r_last_seen;
        w_crc       = r_crc;
        w_crc_sent  = r_crc_sent;
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_accept    = tx_valid && r_tx_ready;
        w_step_end  = (r_cnt == STEP_LAST);
        w_boundary  = (r_state == S_BITS) && w_step_end && (r_step == 4'd1) && (r_bit == 3'd7);

        if ((r_state != S_IDLE) && w_accept) begin
            w_crc       = r_crc ^ tx_data;
            w_last_seen = r_last_seen | tx_last;
            if (!w_boundary) begin
                w_hold      = tx_data;
                w_hold_full = 1'b1;
            end else begin
                w_hold_full = r_hold_full;
            end
        end else begin
            w_crc = w_crc;
        end

        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (w_accept) begin
                    w_state     = S_START;
                    w_step      = 4'd0;
                    w_bit       = 3'd0;
                    w_phase     = 1'b0;
                    w_shift     = tx_data;
                    w_crc       = tx_data;
                    w_last_seen = tx_last;
                    w_hold_full = 1'b0;
                    w_crc_sent  = 1'b0;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_step_end && (r_step == 4'd8)) begin
                    w_state = S_BITS;
                    w_step  = 4'd0;
                    w_bit   = 3'd0;
                end else if (w_step_end) begin
                    w_step = r_step + 4'd1;
                end else begin
                    w_step = r_step;
                end
            end
            S_BITS: begin
                if (w_step_end && (r_step == 4'd0)) begin
                    w_step = 4'd1;
                end else if (w_step_end) begin
                    w_step  = 4'd0;
                    w_phase = ~r_phase;
                    w_bit   = r_bit + 3'd1;
                    // Byte boundary: holding, then same-cycle bypass, then CRC, then end/underrun.
                    if (r_bit != 3'd7) begin
                        w_shift = {r_shift[6:0], 1'b0};
                    end else if (r_hold_full) begin
                        w_shift     = r_hold;
                        w_hold_full = 1'b0;
                    end else if (w_accept) begin
                        w_shift = tx_data;
                    end else if (r_last_seen && APPEND_CRC && !r_crc_sent) begin
                        w_shift    = r_crc;
                        w_crc_sent = 1'b1;
                    end else if (r_last_seen) begin
                        w_state = S_END;
                    end else begin
                        w_error = 1'b1;
                        w_state = S_END;
                    end
                end else begin
                    w_step = r_step;
                end
            end
            S_END: begin
                if (w_step_end && (r_step == 4'd5)) begin
                    w_state = S_IDLE;
                    w_step  = 4'd0;
                    w_done  = 1'b1;
                end else if (w_step_end) begin
                    w_step = r_step + 4'd1;
                end else begin
                    w_step = r_step;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // Pin levels and handshake for the upcoming cycle, from the next state.
    always_comb begin
        w_pin1     = 1'b1;
        w_pin5     = 1'b1;
        w_oe       = (w_state != S_IDLE);
        w_tx_ready = 1'b0;
        w_clk_line = (w_step == 4'd0);
        case (w_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
            end
            S_START: begin
                w_pin1     = 1'b0;
                w_pin5     = ~w_step[0];
                w_tx_ready = !w_hold_full && !w_last_seen;
            end
            S_BITS: begin
                w_pin1     = w_phase ? w_shift[7] : w_clk_line;
                w_pin5     = w_phase ? w_clk_line : w_shift[7];
                w_tx_ready = !w_hold_full && !w_last_seen;
            end
            S_END: begin
                w_pin1 = (w_step == 4'd5) ? 1'b1 : ~w_step[0];
                w_pin5 = (w_step == 4'd5);
            end
            default: begin
                w_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_maple_tx.sv
// Bench for maple_tx: table-driven frames decoded by an independent pin monitor
// against a byte scoreboard, plus bypass, no-CRC and mid-frame reset sequences.
module tb_maple_tx;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;

    logic a_ready, a_busy, a_done, a_err, a_p1, a_p5, a_oe;
    logic b_ready, b_busy, b_done, b_err, b_p1, b_p5, b_oe;
    logic m_ready, m_done, m_err, m_p1, m_p5, m_oe;
    logic a_valid, b_valid;

    assign a_valid = tx_valid & ~sel;
    assign b_valid = tx_valid & sel;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_p1    = sel ? b_p1    : a_p1;
    assign m_p5    = sel ? b_p5    : a_p5;
    assign m_oe    = sel ? b_oe    : a_oe;

    maple_tx #(.STEP_CYCLES(S), .APPEND_CRC(1'b1)) dut (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(a_valid), .tx_last(tx_last),
        .tx_ready(a_ready), .busy(a_busy), .done(a_done), .error(a_err),
        .pin1_out(a_p1), .pin5_out(a_p5), .pin_oe(a_oe));

    maple_tx #(.STEP_CYCLES(S), .APPEND_CRC(1'b0)) dut_nocrc (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(b_valid), .tx_last(tx_last),
        .tx_ready(b_ready), .busy(b_busy), .done(b_done), .error(b_err),
        .pin1_out(b_p1), .pin5_out(b_p5), .pin_oe(b_oe));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int mon_frames = 0;
    int acc_cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    endtask

    // Pulse counters and cycle count, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && m_done) done_cnt <= done_cnt + 1;
        if (!rst && m_err) err_cnt <= err_cnt + 1;
    end

    // Monitor: capture pins while driven, decode the frame when the bus is released.
    logic [1:0] cap[$];
    logic [7:0] got_q[$];
    logic [1:0] st0, st1, ev;
    logic [7:0] cur;
    int len, ns, nb, expn;
    bit bad;
    always @(negedge clk) begin
        if (rst) begin
            cap.delete();
        end else if (m_oe) begin
            cap.push_back({m_p1, m_p5});
        end else if (cap.size() != 0) begin
            bad = 1'b0;
            got_q.delete();
            len = cap.size();
            expn = exp_q.size();
            if ((len % S != 0) || (len < 15 * S) || (((len / S) - 15) % 16 != 0)) begin
                bad = 1'b1;
            end else begin
                ns = len / S;
                for (int k = 0; k < ns; k++)
                    for (int c = 1; c < S; c++)
                        if (cap[k*S+c] != cap[k*S]) bad = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    ev = {1'b0, (k % 2 == 1) ? 1'b0 : 1'b1};
                    if (cap[k*S] != ev) bad = 1'b1;
                end
                for (int j = 0; j < 6; j++) begin
                    ev = (j == 0) ? 2'b10 : (j == 5) ? 2'b11 : {((j % 2 == 1) ? 1'b0 : 1'b1), 1'b0};
                    if (cap[(ns-6+j)*S] != ev) bad = 1'b1;
                end
                cur = 8'h00;
                for (int j = 0; j < (ns - 15) / 2; j++) begin
                    st0 = cap[(9+2*j)*S];
                    st1 = cap[(10+2*j)*S];
                    if (j % 2 == 0) begin
                        if (!(st0[1] && !st1[1] && st0[0] == st1[0])) bad = 1'b1;
                        cur = {cur[6:0], st0[0]};
                    end else begin
                        if (!(st0[0] && !st1[0] && st0[1] == st1[1])) bad = 1'b1;
                        cur = {cur[6:0], st0[1]};
                    end
                    if (j % 8 == 7) got_q.push_back(cur);
                end
            end
            nb = got_q.size();
            check("waveform", int'(bad), 0);
            check("oe_cycles", len, (15 + 16 * expn) * S);
            check("byte_count", nb, expn);
            for (int i = 0; i < nb && exp_q.size() != 0; i++)
                check("byte", int'(got_q[i]), int'(exp_q.pop_front()));
            check("done_at_release", int'(m_done), 1);
            exp_q.delete();
            cap.delete();
            mon_frames <= mon_frames + 1;
        end
    end

    // Present one byte at a negedge and wait for the handshake; returns at the next negedge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        for (int c = 0; c < 4000 && !ok; c++) begin
            if (m_ready) begin
                @(posedge clk);
                acc_cyc = cyc;
                exp_q.push_back(d);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_frame(input int fr);
        for (int c = 0; c < 4000 && mon_frames == fr; c++) @(negedge clk);
        check("frame_seen", int'(mon_frames != fr), 1);
    endtask

    typedef struct {
        int              n;
        logic [3:0][7:0] b;
        bit              last;
        bit              err;
    } vec_t;

    vec_t tbl[4];
    int d0, e0, fr, c0;
    logic [7:0] crc;

    initial begin
        tbl[0] = '{n: 1, b: {8'h00, 8'h00, 8'h00, 8'hA5}, last: 1'b1, err: 1'b0};
        tbl[1] = '{n: 4, b: {8'h08, 8'h04, 8'h02, 8'h01}, last: 1'b1, err: 1'b0};
        tbl[2] = '{n: 1, b: {8'h00, 8'h00, 8'h00, 8'h3C}, last: 1'b0, err: 1'b1};
        tbl[3] = '{n: 2, b: {8'h00, 8'h00, 8'h7E, 8'hC3}, last: 1'b1, err: 1'b0};

        #12;
        check("rst_ready", int'(a_ready), 0);
        check("rst_oe", int'(a_oe), 0);
        check("rst_pins", int'({a_p1, a_p5}), 3);
        check("rst_flags", int'({a_busy, a_done, a_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(a_ready), 1);
        check("idle_ready_nocrc", int'(b_ready), 1);

        for (int t = 0; t < 4; t++) begin
            d0 = done_cnt; e0 = err_cnt; fr = mon_frames; crc = 8'h00;
            for (int i = 0; i < tbl[t].n; i++) begin
                send_byte(tbl[t].b[i], tbl[t].last && (i == tbl[t].n - 1));
                crc = crc ^ tbl[t].b[i];
                if (i == 0) begin
                    check("start_oe", int'(a_oe), 1);
                    check("start_pins", int'({a_p1, a_p5}), 1);
                    check("start_busy", int'(a_busy), 1);
                end
            end
            tx_valid = 1'b0;
            if (tbl[t].last) exp_q.push_back(crc);
            wait_frame(fr);
            check("done_pulses", done_cnt - d0, 1);
            check("err_pulses", err_cnt - e0, int'(tbl[t].err));
            repeat (3) @(negedge clk);
        end

        // Second byte presented exactly on the byte-0 boundary cycle.
        d0 = done_cnt; e0 = err_cnt; fr = mon_frames;
        send_byte(8'h11, 1'b0);
        c0 = acc_cyc;
        tx_valid = 1'b0;
        repeat (25 * S - 1) @(negedge clk);
        send_byte(8'h22, 1'b1);
        tx_valid = 1'b0;
        check("bypass_cycle", acc_cyc - c0, 25 * S);
        exp_q.push_back(8'h33);
        wait_frame(fr);
        check("bypass_err", err_cnt - e0, 0);
        check("bypass_done", done_cnt - d0, 1);
        repeat (3) @(negedge clk);

        // No-CRC instance: single 0xFF frame.
        sel = 1'b1;
        @(negedge clk);
        d0 = done_cnt; fr = mon_frames;
        send_byte(8'hFF, 1'b1);
        tx_valid = 1'b0;
        wait_frame(fr);
        check("nocrc_done", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of the bit stream.
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_oe", int'(a_oe), 0);
        check("midrst_pins", int'({a_p1, a_p5}), 3);
        check("midrst_busy", int'(a_busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        fr = mon_frames;
        send_byte(8'h55, 1'b1);
        tx_valid = 1'b0;
        exp_q.push_back(8'h55);
        wait_frame(fr);
        check("after_rst_done", done_cnt - d0, 1);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/maple_tx.md
# maple_tx

Maple bus frame transmitter for the HDMI clock domain: the transmitting end of the two-wire Maple protocol that `maple` decodes. It takes a byte stream over a valid/ready handshake and serialises it onto MAPLE pin 1 (SDCKA) and pin 5 (SDCKB) with start pattern, alternating-phase data bits, an optional XOR CRC byte and end pattern. It drives the pins through open-drain/tristate enables at the top level, so the OSD/controller logic can query peripherals.

## Interface
- STEP_CYCLES, 18, clocks per half-bit step (~242 ns at 74.25 MHz, ~2 Mbit/s); minimum 2
- APPEND_CRC, 1, 1 = append XOR of all payload bytes after last byte; 0 = none
- clk  input  1  hdmi_clock domain clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- tx_data  input  8  payload byte, MSB transmitted first
- tx_valid  input  1  tx_data valid
- tx_last  input  1  qualifies tx_data as final payload byte of frame
- tx_ready  output  1  byte accepted when tx_valid && tx_ready
- busy  output  1  frame in progress (START..END)
- done  output  1  one-cycle pulse after end pattern completes
- error  output  1  one-cycle pulse on underrun
- pin1_out  output  1  SDCKA drive level
- pin5_out  output  1  SDCKB drive level
- pin_oe  output  1  drive enable for both pins; 0 = released (idle high via pull-up)

## Operation
- All outputs registered. Reset: state IDLE, pin1_out=1, pin5_out=1, pin_oe=0, busy=0, done=0, error=0, tx_ready=0 while reset high, 1 in IDLE thereafter; holding register empty, crc=0x00.
- States: IDLE, START, BITS, END. Step counter counts 0..STEP_CYCLES-1; each step boundary advances the waveform.
- IDLE: tx_ready=1. On accept: byte loaded into shifter, crc=tx_data, last_seen=tx_last, phase=A; next cycle enters START with pin_oe=1.
- START (9 steps): step0 pin1=0, pin5=1; steps 1..8 pin5 = 0 on odd steps, 1 on even; pin1 stays 0.
- BITS: each bit = 2 steps. Phase A: step1 pin1=1, pin5=bit; step2 pin1=0, pin5 held. Phase B: roles swapped (pin5 clock, pin1 data). Receiver samples on clock-line fall. Phase toggles every bit, continuously across byte boundaries; first bit of frame is phase A.
- Holding register (1 byte): during START/BITS, tx_ready=1 iff holding empty and !last_seen. Accept: holding<=tx_data, crc^=tx_data, last_seen|=tx_last.
- Byte boundary (last cycle of bit 7 step 2), priority: holding full -> shifter, holding empty; else accept in same cycle -> bypass straight to shifter (crc still updated); else last_seen && APPEND_CRC && crc not sent -> shifter<=crc; else last_seen -> END; else underrun: error pulse, go END (no CRC).
- END (6 steps): step0 pin1=1, pin5=0; steps1..4 pin1 = 0 on odd, 1 on even; step5 pin5=1, pin1=1. After step5: pin_oe=0, busy=0, done pulse, IDLE.
- busy=1 from cycle after IDLE accept through last END cycle.
- tx_valid without ready: byte held by source; no data loss. tx_last on non-accepted cycles ignored.

## Timing
- Accept in IDLE at cycle T -> pin_oe=1, pin1_out=0 at T+1.
- Frame of N payload bytes, CRC on: pin_oe high (9 + 16(N+1) + 6)·STEP_CYCLES cycles; CRC off: 16N instead of 16(N+1). done at first cycle pin_oe=0.
- Each pin transition occurs exactly on a step boundary; no glitches between steps.
- Async reset mid-frame: pins return to 1/1, pin_oe=0 immediately (no end pattern), busy=0, no done/error.
- tx_ready rises at T+1 after IDLE accept (holding empty), falls the cycle after holding load.

## Test plan
- STEP_CYCLES=4, single byte 0xA5 with tx_last: bits 1,0,1,0,0,1,0,1 then CRC 0xA5 decoded by `maple`-equivalent monitor; pin_oe high 188 cycles; done at T+189.
- Burst 0x01,0x02,0x04,0x08 (last on 0x08), valid held continuously: 4 bytes + CRC 0x0F, no error, 60·4·... pin_oe high (15+80)·4=380 cycles.
- Underrun: one byte 0x3C without tx_last, valid low after: error pulse at byte-0 boundary, END pattern follows immediately, 9+16+6=31 steps, no CRC, done pulses.
- Bypass: second byte presented exactly on byte-0 boundary cycle -> transmitted with no gap, no error.
- APPEND_CRC=0, byte 0xFF last: 8 bits then END; pin_oe high (15+16)·4=124 cycles.
- Reset asserted mid-BITS: same cycle pin_oe=0, pin1/pin5=1, busy=0; after release new frame 0x55 transmits correctly with CRC 0x55.
